// File: rtl/bcd_counter_display_if.sv
// Control and display bundle for bcd_counter_display; DIGITS must match the attached counter.
interface bcd_counter_display_if #(
  parameter int DIGITS = 4
) ();
  logic                  dec;
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count_bcd;
  logic                  tick;
  logic                  threshold;
  logic [6:0]            segments;
  logic [7:0]            anodes;

  modport master (
    output dec, enable, load, load_value,
    input  count_bcd, tick, threshold, segments, anodes
  );

  modport slave (
    input  dec, enable, load, load_value,
    output count_bcd, tick, threshold, segments, anodes
  );
endinterface

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with tick prescaler and multiplexed 7-segment scan.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits above digit 0.
module bcd_digit (
  input  logic [3:0] d_i,
  input  logic       step_i,
  input  logic       dec_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  output logic [3:0] d_o
);
  always_comb begin
    d_o = d_i;
    if (ld_i)
      d_o = (ld_val_i > 4'd9) ? 4'd9 : ld_val_i;
    else if (step_i) begin
      if (dec_i) d_o = (d_i == 4'd0) ? 4'd9 : d_i - 4'd1;
      else       d_o = (d_i == 4'd9) ? 4'd0 : d_i + 4'd1;
    end
  end
endmodule

module bcd_counter_display #(
  parameter int DIGITS    = 4,
  parameter int COUNT_DIV = 100000000,
  parameter int SCAN_DIV  = 100000
) (
  input  logic                   clock,
  input  logic                   reset,
  bcd_counter_display_if.slave   bus
);
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [2:0]            idx_q, idx_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic [DIGITS-1:0]     step;
  logic                  tick, scan_wrap, blank;
  logic [3:0]            sel;
  logic [6:0]            seg;
  logic [7:0]            an;

  assign tick      = (presc_q == PW'(COUNT_DIV - 1));
  assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
  assign presc_d   = tick ? '0 : presc_q + 1'b1;
  assign scan_d    = scan_wrap ? '0 : scan_q + 1'b1;

  always_comb begin
    idx_d = idx_q;
    if (scan_wrap)
      idx_d = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
  end

  // Step enable ripples upward: a digit moves only when every lower digit wraps.
  assign step[0] = bus.enable && tick;
  genvar g;
  generate
    for (g = 1; g < DIGITS; g++) begin : g_chain
      assign step[g] = step[g-1] &&
        (bus.dec ? (count_q[4*(g-1) +: 4] == 4'd0) : (count_q[4*(g-1) +: 4] == 4'd9));
    end
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .d_i      (count_q[4*g +: 4]),
        .step_i   (step[g]),
        .dec_i    (bus.dec),
        .ld_i     (bus.load),
        .ld_val_i (bus.load_value[4*g +: 4]),
        .d_o      (count_d[4*g +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    sel = 4'd0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == 3'(i)) sel = count_q[4*i +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic hi_zero;
  always_comb begin
    blank   = 1'b0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && (count_q[4*i +: 4] == 4'd0);
      if ((idx_q == 3'(i)) && hi_zero) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    case (sel)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
    if (blank) seg = 7'b1111111;
  end

  always_comb begin
    an = 8'hFF;
    for (int i = 0; i < 8; i++)
      if ((i < DIGITS) && (idx_q == 3'(i))) an[i] = 1'b0;
  end

  assign bus.count_bcd = count_q;
  assign bus.tick      = tick;
  assign bus.threshold = bus.dec ? (count_q == '0) : (count_q == {DIGITS{4'h9}});
  assign bus.segments  = seg;
  assign bus.anodes    = an;
endmodule
